csr_mtrap: RTL and testbench

CSR_MTRAP -- requirements
Module: csr_mtrap

---
 rtl/csr_mtrap.sv | 232 +++++++++++++++++++++++
 tb/tb_csr_mtrap.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_mtrap.sv
// Machine-mode trap CSR block: M-mode CSR file, interrupt arbitration, trap entry and MRET.
// Reads are combinational; all architectural state updates on the rising clock edge.
module csr_mtrap #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned NUM_LIRQ    = 4,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     pc_i,
  input  logic                pc_valid_i,
  input  logic                csr_rd_en,
  input  logic                csr_wr_en,
  input  logic [11:0]         csr_idx,
  input  logic [XLEN-1:0]     wbck_csr_data,
  output logic [XLEN-1:0]     read_csr_data,
  output logic                csr_illegal,
  input  logic                excp_ena,
  input  logic [4:0]          excp_cause,
  input  logic [XLEN-1:0]     excp_tval,
  input  logic                cmt_mret_ena,
  input  logic                instret_ena,
  input  logic                ex_stall,
  input  logic                msip_i,
  input  logic                mtip_i,
  input  logic                meip_i,
  input  logic [NUM_LIRQ-1:0] lirq_i,
  output logic                trap_ena,
  output logic [XLEN-1:0]     trap_pc,
  output logic [XLEN-1:0]     mret_pc
);

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MCNTINH  = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  localparam logic [XLEN-1:0] MIE_MASK =
    XLEN'(32'h0000_0888) | (XLEN'((33'd1 << NUM_LIRQ) - 33'd1) << 16);

  logic                mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [1:0]          mst_mpp_q, mst_mpp_d, mst_fs_q, mst_fs_d;
  logic [XLEN-1:0]     mie_q, mie_d;
  logic [XLEN-3:0]     mtvec_base_q, mtvec_base_d;
  logic                mtvec_mode_q, mtvec_mode_d;
  logic                cy_inh_q, cy_inh_d, ir_inh_q, ir_inh_d;
  logic [XLEN-1:0]     mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [XLEN-1:0]     mcause_q, mcause_d, mtval_q, mtval_d;
  logic                msip_q, msip_d, mtip_q, mtip_d, meip_q, meip_d;
  logic [NUM_LIRQ-1:0] lirq_q, lirq_d;
  logic [XLEN-1:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;

  logic [XLEN-1:0]     mip_val, mstatus_val, pending, rd_val, trap_base;
  logic [4:0]          irq_cause, trap_cause;
  logic                irq_take, excp_take, trap_take, mret_take, wr_fire, impl;

  // Composite CSR views and interrupt arbitration (later assignments win = higher priority)
  always_comb begin
    mip_val                  = '0;
    mip_val[3]               = msip_q;
    mip_val[7]               = mtip_q;
    mip_val[11]              = meip_q;
    mip_val[16 +: NUM_LIRQ]  = lirq_q;
    mstatus_val              = '0;
    mstatus_val[3]           = mst_mie_q;
    mstatus_val[7]           = mst_mpie_q;
    mstatus_val[12:11]       = mst_mpp_q;
    mstatus_val[14:13]       = mst_fs_q;
    mstatus_val[XLEN-1]      = (mst_fs_q == 2'b11);
    pending                  = mip_val & mie_q;
    irq_cause                = '0;
    for (int unsigned i = 0; i < NUM_LIRQ; i++) begin
      if (pending[16+i]) irq_cause = 5'(16 + i);
    end
    if (pending[7])  irq_cause = 5'd7;
    if (pending[3])  irq_cause = 5'd3;
    if (pending[11]) irq_cause = 5'd11;
  end

  assign excp_take  = excp_ena & ~ex_stall;
  assign irq_take   = mst_mie_q & (|pending) & pc_valid_i & ~ex_stall;
  assign trap_take  = excp_take | irq_take;
  assign mret_take  = cmt_mret_ena & ~ex_stall & ~trap_take;
  assign wr_fire    = csr_wr_en & ~ex_stall;
  assign trap_cause = excp_take ? excp_cause : irq_cause;
  assign trap_base  = {mtvec_base_q, 2'b00};

  assign trap_ena = trap_take;
  assign trap_pc  = (mtvec_mode_q && !excp_take) ? trap_base + XLEN'({trap_cause, 2'b00})
                                                 : trap_base;
  assign mret_pc  = mepc_q;

  // Combinational read mux; unknown indices flag csr_illegal
  always_comb begin
    rd_val = '0;
    impl   = 1'b1;
    case (csr_idx)
      CSR_MSTATUS:  rd_val = mstatus_val;
      CSR_MIE:      rd_val = mie_q;
      CSR_MTVEC:    rd_val = {mtvec_base_q, 1'b0, mtvec_mode_q};
      CSR_MCNTINH:  begin rd_val[0] = cy_inh_q; rd_val[2] = ir_inh_q; end
      CSR_MSCRATCH: rd_val = mscratch_q;
      CSR_MEPC:     rd_val = mepc_q;
      CSR_MCAUSE:   rd_val = mcause_q;
      CSR_MTVAL:    rd_val = mtval_q;
      CSR_MIP:      rd_val = mip_val;
      CSR_MCYCLE:   rd_val = mcycle_q;
      CSR_MINSTRET: rd_val = minstret_q;
      default:      impl = 1'b0;
    endcase
  end

  assign read_csr_data = csr_rd_en ? rd_val : '0;
  assign csr_illegal   = (csr_rd_en | csr_wr_en) & ~impl;

  // Next state: counters, then CSR write, then trap/MRET overriding the trap-owned fields
  always_comb begin
    mst_mie_d    = mst_mie_q;
    mst_mpie_d   = mst_mpie_q;
    mst_mpp_d    = mst_mpp_q;
    mst_fs_d     = mst_fs_q;
    mie_d        = mie_q;
    mtvec_base_d = mtvec_base_q;
    mtvec_mode_d = mtvec_mode_q;
    cy_inh_d     = cy_inh_q;
    ir_inh_d     = ir_inh_q;
    mscratch_d   = mscratch_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;
    mtval_d      = mtval_q;
    msip_d       = msip_q;
    mtip_d       = mtip_i;
    meip_d       = meip_i;
    lirq_d       = lirq_i;
    mcycle_d     = cy_inh_q ? mcycle_q : mcycle_q + XLEN'(1);
    minstret_d   = (instret_ena && !ex_stall && !ir_inh_q) ? minstret_q + XLEN'(1) : minstret_q;
    if (wr_fire) begin
      case (csr_idx)
        CSR_MSTATUS: begin
          mst_mie_d  = wbck_csr_data[3];
          mst_mpie_d = wbck_csr_data[7];
          mst_mpp_d  = (wbck_csr_data[12:11] == 2'b11) ? 2'b11 : 2'b00;
          mst_fs_d   = wbck_csr_data[14:13];
        end
        CSR_MIE:      mie_d = wbck_csr_data & MIE_MASK;
        CSR_MTVEC: begin
          mtvec_base_d = wbck_csr_data[XLEN-1:2];
          mtvec_mode_d = VECTORED_EN && (wbck_csr_data[1:0] == 2'b01);
        end
        CSR_MCNTINH: begin
          cy_inh_d = wbck_csr_data[0];
          ir_inh_d = wbck_csr_data[2];
        end
        CSR_MSCRATCH: mscratch_d = wbck_csr_data;
        CSR_MEPC:     mepc_d     = wbck_csr_data & ~XLEN'(3);
        CSR_MCAUSE:   mcause_d   = wbck_csr_data;
        CSR_MTVAL:    mtval_d    = wbck_csr_data;
        CSR_MIP:      msip_d     = wbck_csr_data[3];
        CSR_MCYCLE:   mcycle_d   = wbck_csr_data;
        CSR_MINSTRET: minstret_d = wbck_csr_data;
        default: ;
      endcase
    end
    if (msip_i) msip_d = 1'b1;
    if (trap_take) begin
      mepc_d          = pc_i & ~XLEN'(3);
      mcause_d        = '0;
      mcause_d[XLEN-1] = ~excp_take;
      mcause_d[4:0]   = trap_cause;
      mtval_d         = excp_take ? excp_tval : '0;
      mst_mpie_d      = mst_mie_q;
      mst_mie_d       = 1'b0;
      mst_mpp_d       = 2'b11;
    end else if (mret_take) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
      mst_mpp_d  = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie_q    <= 1'b0;
      mst_mpie_q   <= 1'b0;
      mst_mpp_q    <= 2'b00;
      mst_fs_q     <= 2'b00;
      mie_q        <= '0;
      mtvec_base_q <= '0;
      mtvec_mode_q <= 1'b0;
      cy_inh_q     <= 1'b0;
      ir_inh_q     <= 1'b0;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      msip_q       <= 1'b0;
      mtip_q       <= 1'b0;
      meip_q       <= 1'b0;
      lirq_q       <= '0;
      mcycle_q     <= '0;
      minstret_q   <= '0;
    end else begin
      mst_mie_q    <= mst_mie_d;
      mst_mpie_q   <= mst_mpie_d;
      mst_mpp_q    <= mst_mpp_d;
      mst_fs_q     <= mst_fs_d;
      mie_q        <= mie_d;
      mtvec_base_q <= mtvec_base_d;
      mtvec_mode_q <= mtvec_mode_d;
      cy_inh_q     <= cy_inh_d;
      ir_inh_q     <= ir_inh_d;
      mscratch_q   <= mscratch_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
      mtval_q      <= mtval_d;
      msip_q       <= msip_d;
      mtip_q       <= mtip_d;
      meip_q       <= meip_d;
      lirq_q       <= lirq_d;
      mcycle_q     <= mcycle_d;
      minstret_q   <= minstret_d;
    end
  end

endmodule

// File: tb/tb_csr_mtrap.sv
// Directed self-checking bench for csr_mtrap (XLEN=64, NUM_LIRQ=4, vectored mode enabled).
module tb_csr_mtrap;
  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [XLEN-1:0] pc_i = '0;
  logic            pc_valid_i = 1'b0;
  logic            csr_rd_en = 1'b0, csr_wr_en = 1'b0;
  logic [11:0]     csr_idx = '0;
  logic [XLEN-1:0] wbck_csr_data = '0;
  logic [XLEN-1:0] read_csr_data;
  logic            csr_illegal;
  logic            excp_ena = 1'b0;
  logic [4:0]      excp_cause = '0;
  logic [XLEN-1:0] excp_tval = '0;
  logic            cmt_mret_ena = 1'b0, instret_ena = 1'b0, ex_stall = 1'b0;
  logic            msip_i = 1'b0, mtip_i = 1'b0, meip_i = 1'b0;
  logic [3:0]      lirq_i = '0;
  logic            trap_ena;
  logic [XLEN-1:0] trap_pc, mret_pc;

  int n_checks = 0;
  int n_fail   = 0;

  csr_mtrap #(.XLEN(64), .NUM_LIRQ(4), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i),
    .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_idx(csr_idx),
    .wbck_csr_data(wbck_csr_data), .read_csr_data(read_csr_data), .csr_illegal(csr_illegal),
    .excp_ena(excp_ena), .excp_cause(excp_cause), .excp_tval(excp_tval),
    .cmt_mret_ena(cmt_mret_ena), .instret_ena(instret_ena), .ex_stall(ex_stall),
    .msip_i(msip_i), .mtip_i(mtip_i), .meip_i(meip_i), .lirq_i(lirq_i),
    .trap_ena(trap_ena), .trap_pc(trap_pc), .mret_pc(mret_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  // Called at a negedge; write lands on the next posedge, returns at the following negedge.
  task automatic csr_wr(input logic [11:0] idx, input logic [XLEN-1:0] d);
    csr_wr_en = 1'b1; csr_idx = idx; wbck_csr_data = d;
    @(negedge clk);
    csr_wr_en = 1'b0;
  endtask

  // Called at a negedge; samples 1 time unit later and consumes one cycle.
  task automatic csr_rd(input logic [11:0] idx, output logic [XLEN-1:0] d);
    csr_rd_en = 1'b1; csr_idx = idx;
    #1 d = read_csr_data;
    @(negedge clk);
    csr_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] d;
    repeat (2) @(negedge clk);
    n_checks++; if (trap_ena !== 1'b0) begin n_fail++; $display("FAIL rst_trap_ena: got %b exp 0", trap_ena); end
    n_checks++; if (csr_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_illegal: got %b exp 0", csr_illegal); end
    rst = 1'b0;
    csr_rd(12'hB00, d);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL rst_mcycle0: got %h exp 0", d); end
    csr_rd(12'hB00, d);
    n_checks++; if (d !== 64'h1) begin n_fail++; $display("FAIL rst_mcycle1: got %h exp 1", d); end
    csr_rd(12'h300, d);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL rst_mstatus: got %h exp 0", d); end
    csr_rd(12'h305, d);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL rst_mtvec: got %h exp 0", d); end
  endtask

  task automatic test_csr_fields();
    logic [XLEN-1:0] d;
    csr_wr(12'h300, 64'hFFFF_FFFF_FFFF_FFFF); csr_rd(12'h300, d);
    n_checks++; if (d !== 64'h8000_0000_0000_7888) begin n_fail++; $display("FAIL mstatus_ones: got %h exp 8000000000007888", d); end
    csr_wr(12'h300, 64'h1000); csr_rd(12'h300, d);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL mstatus_mpp10: got %h exp 0", d); end
    csr_wr(12'h300, 64'h2000); csr_rd(12'h300, d);
    n_checks++; if (d !== 64'h2000) begin n_fail++; $display("FAIL mstatus_fs01: got %h exp 2000", d); end
    csr_wr(12'h300, 64'h0);
    csr_wr(12'h305, 64'h8000_0003); csr_rd(12'h305, d);
    n_checks++; if (d !== 64'h8000_0000) begin n_fail++; $display("FAIL mtvec_mode3: got %h exp 80000000", d); end
    csr_wr(12'h305, 64'h8000_0002); csr_rd(12'h305, d);
    n_checks++; if (d !== 64'h8000_0000) begin n_fail++; $display("FAIL mtvec_mode2: got %h exp 80000000", d); end
    csr_wr(12'h305, 64'h8000_0001); csr_rd(12'h305, d);
    n_checks++; if (d !== 64'h8000_0001) begin n_fail++; $display("FAIL mtvec_mode1: got %h exp 80000001", d); end
    csr_wr(12'h304, 64'hFFFF_FFFF_FFFF_FFFF); csr_rd(12'h304, d);
    n_checks++; if (d !== 64'hF_0888) begin n_fail++; $display("FAIL mie_mask: got %h exp f0888", d); end
    csr_wr(12'h304, 64'h0);
    csr_wr(12'h341, 64'h1237); csr_rd(12'h341, d);
    n_checks++; if (d !== 64'h1234) begin n_fail++; $display("FAIL mepc_align: got %h exp 1234", d); end
    csr_wr(12'h320, 64'hFF); csr_rd(12'h320, d);
    n_checks++; if (d !== 64'h5) begin n_fail++; $display("FAIL mcntinh_mask: got %h exp 5", d); end
    csr_wr(12'h320, 64'h0);
    csr_wr(12'h344, 64'hFFFF_FFFF_FFFF_FFFF); csr_rd(12'h344, d);
    n_checks++; if (d !== 64'h8) begin n_fail++; $display("FAIL mip_write: got %h exp 8", d); end
    csr_wr(12'h344, 64'h0); csr_rd(12'h344, d);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL mip_clear: got %h exp 0", d); end
    msip_i = 1'b1; @(negedge clk); msip_i = 1'b0; csr_rd(12'h344, d);
    n_checks++; if (d !== 64'h8) begin n_fail++; $display("FAIL mip_msip_in: got %h exp 8", d); end
    csr_wr(12'h344, 64'h0);
    mtip_i = 1'b1; @(negedge clk); csr_rd(12'h344, d);
    n_checks++; if (d !== 64'h80) begin n_fail++; $display("FAIL mip_mtip_in: got %h exp 80", d); end
    mtip_i = 1'b0; @(negedge clk);
    csr_rd_en = 1'b1; csr_idx = 12'h7C0;
    #1;
    n_checks++; if (csr_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got %b exp 1", csr_illegal); end
    n_checks++; if (read_csr_data !== 64'h0) begin n_fail++; $display("FAIL illegal_data: got %h exp 0", read_csr_data); end
    csr_idx = 12'h340;
    #1;
    n_checks++; if (csr_illegal !== 1'b0) begin n_fail++; $display("FAIL legal_flag: got %b exp 0", csr_illegal); end
    csr_rd_en = 1'b0;
    @(negedge clk);
    csr_wr(12'h340, 64'h1111);
    csr_rd_en = 1'b1; csr_wr_en = 1'b1; csr_idx = 12'h340; wbck_csr_data = 64'h2222;
    #1;
    n_checks++; if (read_csr_data !== 64'h1111) begin n_fail++; $display("FAIL rd_during_wr: got %h exp 1111", read_csr_data); end
    @(negedge clk);
    csr_wr_en = 1'b0; csr_rd_en = 1'b0;
    csr_rd(12'h340, d);
    n_checks++; if (d !== 64'h2222) begin n_fail++; $display("FAIL wr_after_rd: got %h exp 2222", d); end
  endtask

  task automatic test_vectored_irq();
    logic [XLEN-1:0] d;
    csr_wr(12'h305, 64'h8000_0001);
    csr_wr(12'h304, 64'h80);
    csr_wr(12'h300, 64'h8);
    pc_i = 64'h1004; pc_valid_i = 1'b1; mtip_i = 1'b1;
    #1;
    n_checks++; if (trap_ena !== 1'b0) begin n_fail++; $display("FAIL irq_latency: got %b exp 0", trap_ena); end
    @(negedge clk);
    n_checks++; if (trap_ena !== 1'b1) begin n_fail++; $display("FAIL irq_trap_ena: got %b exp 1", trap_ena); end
    n_checks++; if (trap_pc !== 64'h8000_001C) begin n_fail++; $display("FAIL irq_trap_pc: got %h exp 8000001c", trap_pc); end
    @(negedge clk);
    pc_valid_i = 1'b0; mtip_i = 1'b0;
    csr_rd(12'h342, d);
    n_checks++; if (d !== 64'h8000_0000_0000_0007) begin n_fail++; $display("FAIL irq_mcause: got %h exp 8000000000000007", d); end
    csr_rd(12'h341, d);
    n_checks++; if (d !== 64'h1004) begin n_fail++; $display("FAIL irq_mepc: got %h exp 1004", d); end
    csr_rd(12'h300, d);
    n_checks++; if (d !== 64'h1880) begin n_fail++; $display("FAIL irq_mstatus: got %h exp 1880", d); end
    csr_rd(12'h343, d);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL irq_mtval: got %h exp 0", d); end
  endtask

  task automatic test_mret();
    logic [XLEN-1:0] d;
    cmt_mret_ena = 1'b1;
    #1;
    n_checks++; if (mret_pc !== 64'h1004) begin n_fail++; $display("FAIL mret_pc: got %h exp 1004", mret_pc); end
    @(negedge clk);
    cmt_mret_ena = 1'b0;
    csr_rd(12'h300, d);
    n_checks++; if (d !== 64'h88) begin n_fail++; $display("FAIL mret_mstatus: got %h exp 88", d); end
  endtask

  task automatic test_exception();
    logic [XLEN-1:0] d;
    mtip_i = 1'b1; @(negedge clk);
    excp_ena = 1'b1; excp_cause = 5'd2; excp_tval = 64'hDEAD; pc_i = 64'h3006; pc_valid_i = 1'b1;
    #1;
    n_checks++; if (trap_ena !== 1'b1) begin n_fail++; $display("FAIL excp_trap_ena: got %b exp 1", trap_ena); end
    n_checks++; if (trap_pc !== 64'h8000_0000) begin n_fail++; $display("FAIL excp_trap_pc: got %h exp 80000000", trap_pc); end
    @(negedge clk);
    excp_ena = 1'b0; pc_valid_i = 1'b0; mtip_i = 1'b0;
    csr_rd(12'h342, d);
    n_checks++; if (d !== 64'h2) begin n_fail++; $display("FAIL excp_mcause: got %h exp 2", d); end
    csr_rd(12'h343, d);
    n_checks++; if (d !== 64'hDEAD) begin n_fail++; $display("FAIL excp_mtval: got %h exp dead", d); end
    csr_rd(12'h341, d);
    n_checks++; if (d !== 64'h3004) begin n_fail++; $display("FAIL excp_mepc: got %h exp 3004", d); end
  endtask

  task automatic test_priority();
    logic [XLEN-1:0] d;
    csr_wr(12'h304, 64'h8_0888);
    csr_wr(12'h300, 64'h8);
    meip_i = 1'b1; mtip_i = 1'b1; lirq_i = 4'b1000; pc_i = 64'h2000;
    @(negedge clk);
    pc_valid_i = 1'b1;
    #1;
    n_checks++; if (trap_pc !== 64'h8000_002C) begin n_fail++; $display("FAIL prio_mei_pc: got %h exp 8000002c", trap_pc); end
    @(negedge clk);
    pc_valid_i = 1'b0;
    csr_rd(12'h342, d);
    n_checks++; if (d !== 64'h8000_0000_0000_000B) begin n_fail++; $display("FAIL prio_mei_cause: got %h exp 800000000000000b", d); end
    csr_rd(12'h343, d);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL prio_irq_mtval: got %h exp 0", d); end
    meip_i = 1'b0;
    csr_wr(12'h300, 64'h8);
    pc_valid_i = 1'b1;
    #1;
    n_checks++; if (trap_pc !== 64'h8000_001C) begin n_fail++; $display("FAIL prio_mti_pc: got %h exp 8000001c", trap_pc); end
    @(negedge clk);
    pc_valid_i = 1'b0;
    csr_rd(12'h342, d);
    n_checks++; if (d !== 64'h8000_0000_0000_0007) begin n_fail++; $display("FAIL prio_mti_cause: got %h exp 8000000000000007", d); end
    mtip_i = 1'b0;
    csr_wr(12'h300, 64'h8);
    pc_valid_i = 1'b1;
    #1;
    n_checks++; if (trap_pc !== 64'h8000_004C) begin n_fail++; $display("FAIL prio_lirq_pc: got %h exp 8000004c", trap_pc); end
    @(negedge clk);
    pc_valid_i = 1'b0; lirq_i = 4'b0000;
    csr_rd(12'h342, d);
    n_checks++; if (d !== 64'h8000_0000_0000_0013) begin n_fail++; $display("FAIL prio_lirq_cause: got %h exp 8000000000000013", d); end
  endtask

  task automatic test_stall();
    logic [XLEN-1:0] d;
    csr_wr(12'h340, 64'h2222);
    csr_wr(12'h304, 64'h80);
    csr_wr(12'h300, 64'h8);
    mtip_i = 1'b1; @(negedge clk);
    ex_stall = 1'b1; pc_valid_i = 1'b1;
    csr_wr_en = 1'b1; csr_idx = 12'h340; wbck_csr_data = 64'h5555;
    #1;
    n_checks++; if (trap_ena !== 1'b0) begin n_fail++; $display("FAIL stall_no_trap: got %b exp 0", trap_ena); end
    @(negedge clk);
    csr_wr_en = 1'b0;
    csr_rd(12'h340, d);
    n_checks++; if (d !== 64'h2222) begin n_fail++; $display("FAIL stall_no_write: got %h exp 2222", d); end
    ex_stall = 1'b0;
    csr_wr_en = 1'b1; csr_idx = 12'h340; wbck_csr_data = 64'h7777;
    #1;
    n_checks++; if (trap_ena !== 1'b1) begin n_fail++; $display("FAIL unstall_trap: got %b exp 1", trap_ena); end
    @(negedge clk);
    csr_wr_en = 1'b0; pc_valid_i = 1'b0; mtip_i = 1'b0;
    csr_rd(12'h340, d);
    n_checks++; if (d !== 64'h7777) begin n_fail++; $display("FAIL trap_wr_other: got %h exp 7777", d); end
    csr_rd(12'h300, d);
    n_checks++; if (d !== 64'h1880) begin n_fail++; $display("FAIL unstall_mstatus: got %h exp 1880", d); end
    csr_rd(12'h341, d);
    n_checks++; if (d !== 64'h2000) begin n_fail++; $display("FAIL unstall_mepc: got %h exp 2000", d); end
  endtask

  task automatic test_counters();
    logic [XLEN-1:0] d;
    csr_wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    csr_rd(12'hB00, d);
    n_checks++; if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL mcycle_wr: got %h exp ffffffffffffffff", d); end
    csr_rd(12'hB00, d);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL mcycle_wrap: got %h exp 0", d); end
    csr_wr(12'hB02, 64'h5);
    instret_ena = 1'b1; repeat (3) @(negedge clk); instret_ena = 1'b0;
    csr_rd(12'hB02, d);
    n_checks++; if (d !== 64'h8) begin n_fail++; $display("FAIL minstret_inc: got %h exp 8", d); end
    ex_stall = 1'b1; instret_ena = 1'b1; @(negedge clk); ex_stall = 1'b0; instret_ena = 1'b0;
    csr_rd(12'hB02, d);
    n_checks++; if (d !== 64'h8) begin n_fail++; $display("FAIL minstret_stall: got %h exp 8", d); end
    csr_wr(12'h320, 64'h5);
    csr_wr(12'hB00, 64'h100);
    instret_ena = 1'b1; repeat (3) @(negedge clk); instret_ena = 1'b0;
    csr_rd(12'hB00, d);
    n_checks++; if (d !== 64'h100) begin n_fail++; $display("FAIL mcycle_inhibit: got %h exp 100", d); end
    csr_rd(12'hB02, d);
    n_checks++; if (d !== 64'h8) begin n_fail++; $display("FAIL minstret_inhibit: got %h exp 8", d); end
    csr_wr(12'h320, 64'h0);
    csr_rd(12'hB00, d);
    csr_rd(12'hB00, d);
    n_checks++; if (d !== 64'h101) begin n_fail++; $display("FAIL mcycle_resume: got %h exp 101", d); end
  endtask

  task automatic test_reset_mid();
    logic [XLEN-1:0] d;
    csr_wr(12'h304, 64'h80);
    csr_wr(12'h300, 64'h8);
    csr_wr(12'h340, 64'hABCD);
    mtip_i = 1'b1; @(negedge clk);
    pc_valid_i = 1'b1; pc_i = 64'h4000; rst = 1'b1;
    csr_wr_en = 1'b1; csr_idx = 12'h340; wbck_csr_data = 64'h1234;
    @(negedge clk);
    rst = 1'b0; csr_wr_en = 1'b0; pc_valid_i = 1'b0; mtip_i = 1'b0;
    csr_rd(12'hB00, d);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL midrst_mcycle: got %h exp 0", d); end
    n_checks++; if (trap_ena !== 1'b0) begin n_fail++; $display("FAIL midrst_trap_ena: got %b exp 0", trap_ena); end
    csr_rd(12'h341, d);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL midrst_mepc: got %h exp 0", d); end
    csr_rd(12'h300, d);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL midrst_mstatus: got %h exp 0", d); end
    csr_rd(12'h340, d);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL midrst_mscratch: got %h exp 0", d); end
  endtask

  initial begin
    test_reset();
    test_csr_fields();
    test_vectored_irq();
    test_mret();
    test_exception();
    test_priority();
    test_stall();
    test_counters();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
